// File: rtl/arb_mem_slave_if.sv
// Request/response bus between the round-robin arbiter (master) and the memory target (slave).
// The arbiter drives the granted request and receives the one-cycle response strobe.
interface arb_mem_slave_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_ack;
  logic              err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rdata, rdata_ack, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rdata, rdata_ack, err
  );
endinterface

// File: rtl/arb_mem_slave.sv
// Memory target behind the arbiter: one outstanding read/write at a time, fixed access
// latency, single-cycle response strobe with an error qualifier for illegal addresses.
module arb_mem_slave #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 2
) (
  input  logic          clk,
  input  logic          reset,
  arb_mem_slave_if.slave bus
);
  localparam int         ADDR_W   = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                write_r;
  logic                legal_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                ready_r;
  logic                ack_r;
  logic                err_r;
  logic                commit_s;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  // Word aligned and no address bits above the array's index range.
  function automatic logic addr_legal(input logic [31:0] addr);
    logic [31:0] hi;
    hi = addr >> (ADDR_W + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

  // Write commits on the same edge that enters RESP, only for legal writes.
  always_comb begin
    commit_s = 1'b0;
    if ((state_r == WAIT) && (cnt_r == 4'd0) && write_r && legal_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Request/latency/response sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      write_r <= 1'b0;
      legal_r <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      ready_r <= 1'b1;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          rdata_r <= '0;
          err_r   <= 1'b0;
          if (bus.req_valid && ready_r) begin
            write_r <= bus.req_write;
            legal_r <= addr_legal(bus.req_addr);
            idx_r   <= bus.req_addr[ADDR_W+1:2];
            wdata_r <= bus.req_wdata;
            cnt_r   <= CNT_LOAD;
            ready_r <= 1'b0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
            ack_r   <= 1'b1;
            err_r   <= ~legal_r;
            // Writes and illegal accesses answer with zero data.
            rdata_r <= (legal_r && !write_r) ? mem[idx_r] : '0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          rdata_r <= '0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          rdata_r <= '0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem[idx_r] <= wdata_r;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rdata     = rdata_r;
  assign bus.rdata_ack = ack_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_arb_mem_slave.sv
// Directed bench for arb_mem_slave: vector table of single transactions plus hand-written
// sequences for back-to-back requests, input changes while busy, reset aborts and latency sweep.
module tb_arb_mem_slave;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arb_mem_slave_if #(.DATA_W(32)) m   ();
  arb_mem_slave_if #(.DATA_W(32)) s1  ();
  arb_mem_slave_if #(.DATA_W(32)) s15 ();

  arb_mem_slave #(.DATA_W(32), .MEM_DEPTH(256), .LATENCY(2))  dut    (.clk(clk), .reset(reset), .bus(m));
  arb_mem_slave #(.DATA_W(32), .MEM_DEPTH(256), .LATENCY(1))  dut_l1 (.clk(clk), .reset(reset), .bus(s1));
  arb_mem_slave #(.DATA_W(32), .MEM_DEPTH(256), .LATENCY(15)) dut_l15(.clk(clk), .reset(reset), .bus(s15));

  logic        sw_valid;
  logic        sw_write;
  logic [31:0] sw_addr;
  logic [31:0] sw_wdata;
  assign s1.req_valid  = sw_valid;
  assign s1.req_write  = sw_write;
  assign s1.req_addr   = sw_addr;
  assign s1.req_wdata  = sw_wdata;
  assign s15.req_valid = sw_valid;
  assign s15.req_write = sw_write;
  assign s15.req_addr  = sw_addr;
  assign s15.req_wdata = sw_wdata;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;
  int   n_bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; starts and ends on a falling edge.
  task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_er);
    int   n;
    int   lat;
    logic quiet;
    n = 0;
    while (m.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    m.req_valid = 1'b1;
    m.req_write = w;
    m.req_addr  = a;
    m.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    m.req_write = ~w;
    m.req_addr  = 32'h0000_0024;
    m.req_wdata = 32'hFFFF_FFFF;
    quiet = 1'b1;
    lat   = 0;
    while (m.rdata_ack !== 1'b1 && lat < 40) begin
      if (m.rdata !== 32'd0 || m.err !== 1'b0 || m.req_ready !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({nm, "/latency"}, 32'(lat), 32'd2);
    check({nm, "/rdata"}, m.rdata, exp_rd);
    check({nm, "/err"}, {31'd0, m.err}, {31'd0, exp_er});
    check({nm, "/busy_quiet"}, {31'd0, quiet}, 32'd1);
    @(negedge clk);
    check({nm, "/ack_one_cycle"}, {31'd0, m.rdata_ack}, 32'd0);
    check({nm, "/ready_back"}, {31'd0, m.req_ready}, 32'd1);
  endtask

  initial begin
    int   lat1;
    int   lat15;
    int   c1;
    int   c15;
    int   acc[3];
    int   acc_n;
    int   ack_n;
    int   low_n;
    int   n;
    logic quiet;

    n_vec = 0;
    n_bad = 0;
    m.req_valid = 1'b0;
    m.req_write = 1'b0;
    m.req_addr  = 32'd0;
    m.req_wdata = 32'd0;
    sw_valid = 1'b0;
    sw_write = 1'b0;
    sw_addr  = 32'd0;
    sw_wdata = 32'd0;
    reset = 1'b1;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hA5A5_0001, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0402, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'h0000_0099, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0030, 32'h0000_0055, 32'h0000_0000, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset/ready", {31'd0, m.req_ready}, 32'd1);
    check("reset/ack", {31'd0, m.rdata_ack}, 32'd0);
    check("reset/rdata", m.rdata, 32'd0);
    check("reset/err", {31'd0, m.err}, 32'd0);

    // Latency sweep: both instances accept on the same edge.
    sw_valid = 1'b1;
    sw_write = 1'b1;
    sw_addr  = 32'h0000_0008;
    sw_wdata = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    sw_valid = 1'b0;
    lat1 = -1; lat15 = -1; c1 = 0; c15 = 0;
    for (int i = 0; i < 20; i++) begin
      if (s1.rdata_ack === 1'b1) begin
        c1++;
        if (lat1 < 0) lat1 = i;
      end
      if (s15.rdata_ack === 1'b1) begin
        c15++;
        if (lat15 < 0) lat15 = i;
      end
      @(negedge clk);
    end
    check("sweep/lat1", 32'(lat1), 32'd1);
    check("sweep/lat15", 32'(lat15), 32'd15);
    check("sweep/acks1", 32'(c1), 32'd1);
    check("sweep/acks15", 32'(c15), 32'd1);

    for (int i = 0; i < 12; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Request inputs scrambled during WAIT must not affect the committed write.
    txn("busy_write", 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0000_0000, 1'b0);
    txn("busy_rd20", 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_1234, 1'b0);
    txn("busy_rd24", 1'b0, 32'h0000_0024, 32'h0000_0000, 32'h0000_0099, 1'b0);
    txn("busy_rd10", 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hA5A5_0001, 1'b0);

    // req_valid held high across three reads.
    m.req_valid = 1'b1;
    m.req_write = 1'b0;
    m.req_addr  = 32'h0000_0010;
    acc_n = 0; ack_n = 0; low_n = 0;
    for (int c = 0; c < 40 && ack_n < 3; c++) begin
      if (m.req_ready === 1'b0) low_n++;
      if (m.rdata_ack === 1'b1) begin
        ack_n++;
        check("hold/rdata", m.rdata, 32'hA5A5_0001);
        check("hold/ready_at_ack", {31'd0, m.req_ready}, 32'd0);
        if (ack_n == 3) m.req_valid = 1'b0;
      end
      if (m.req_ready === 1'b1 && m.req_valid === 1'b1 && acc_n < 3) begin
        acc[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    m.req_valid = 1'b0;
    check("hold/acks", 32'(ack_n), 32'd3);
    check("hold/accepts", 32'(acc_n), 32'd3);
    check("hold/spacing01", 32'(acc[1] - acc[0]), 32'd4);
    check("hold/spacing12", 32'(acc[2] - acc[1]), 32'd4);
    check("hold/busy_cycles", 32'(low_n), 32'd9);
    repeat (2) @(negedge clk);
    check("hold/no_extra_ack", {31'd0, m.rdata_ack}, 32'd0);
    check("hold/idle_ready", {31'd0, m.req_ready}, 32'd1);

    // Reset during WAIT of a write to 0x30 drops the write.
    m.req_valid = 1'b1;
    m.req_write = 1'b1;
    m.req_addr  = 32'h0000_0030;
    m.req_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_wait/ack", {31'd0, m.rdata_ack}, 32'd0);
    check("rst_wait/rdata", m.rdata, 32'd0);
    check("rst_wait/err", {31'd0, m.err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m.rdata_ack !== 1'b0) quiet = 1'b0;
    end
    check("rst_wait/no_ack", {31'd0, quiet}, 32'd1);
    txn("rst_wait/rd30", 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0055, 1'b0);

    // Reset during RESP clears the response at once.
    m.req_valid = 1'b1;
    m.req_write = 1'b0;
    m.req_addr  = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    n = 0;
    while (m.rdata_ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_resp/ack_seen", {31'd0, m.rdata_ack}, 32'd1);
    check("rst_resp/rdata_before", m.rdata, 32'hA5A5_0001);
    reset = 1'b1;
    #1;
    check("rst_resp/ack", {31'd0, m.rdata_ack}, 32'd0);
    check("rst_resp/rdata", m.rdata, 32'd0);
    check("rst_resp/ready", {31'd0, m.req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn("rst_resp/rd10", 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hA5A5_0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
